barrett_reduce_pipe: RTL

//  Pipelined, parametrised Barrett modular reducer: dout_r = din_a mod Q for any din_a < 2**IN_W.

---
 rtl/barrett_pkg.sv | 28 ++
 rtl/barrett_corr.sv | 24 ++
 rtl/barrett_reduce_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reducer.
package barrett_pkg;

    localparam int K_GUARD = 1;  // K = IN_W + K_GUARD keeps qhat within 2 of the true quotient
    localparam int R_GUARD = 2;  // stage-2 width W + R_GUARD holds any r0 < 3Q

    function automatic int clog2(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++) begin
            if ((longint'(1) << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int barrett_k(input int in_w);
        return in_w + K_GUARD;
    endfunction

    function automatic int barrett_rw(input int w);
        return w + R_GUARD;
    endfunction

    function automatic longint barrett_m(input longint q, input int k);
        return (longint'(1) << k) / q;
    endfunction

endpackage

// File: rtl/barrett_corr.sv
// Final Barrett correction: folds r0 in [0, 3Q) down to [0, Q).
module barrett_corr
    import barrett_pkg::*;
#(
    parameter int Q = 2273,
    parameter int W = clog2(Q)
) (
    input  logic [W+1:0] r0,
    output logic [W-1:0] r
);

    localparam logic [W+1:0] Q1 = (W+2)'(Q);
    localparam logic [W+1:0] Q2 = (W+2)'(2 * Q);

    always_comb begin
        r = W'(r0);
        if (r0 >= Q2) begin
            r = W'(r0 - Q2);
        end else if (r0 >= Q1) begin
            r = W'(r0 - Q1);
        end
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer (dout_r = din_a mod Q) with valid/ready and tag.
// Optional range flag dout_ovf (din_a >= Q*Q) when BARRETT_RANGE_CHK_EN is defined.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int Q     = 2273,
    parameter int W     = clog2(Q),
    parameter int IN_W  = 2 * W - 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [IN_W-1:0]  din_a,
    input  logic [TAG_W-1:0] din_tag,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [W-1:0]     dout_r,
    output logic [TAG_W-1:0] dout_tag
`ifdef BARRETT_RANGE_CHK_EN
    ,
    output logic             dout_ovf
`endif
);

    localparam int K  = barrett_k(IN_W);
    localparam int RW = barrett_rw(W);
    localparam int PW = IN_W + K;
    localparam logic [PW-1:0] M_C  = PW'(barrett_m(Q, K));
    localparam logic [RW-1:0] Q_RW = RW'(Q);

    logic             en;
    logic             vld_p0, vld_p1, vld_p2;
    logic [RW-1:0]    qhat_c;
    logic [RW-1:0]    qhat_p0, a_p0;
    logic [RW-1:0]    r0_p1;
    logic [TAG_W-1:0] tag_p0, tag_p1;
    logic [W-1:0]     r_corr;

    assign en         = !vld_p2 || dout_ready;
    assign din_ready  = en;
    assign dout_valid = vld_p2;

    // r0 is only ever < 3Q, so the low RW bits of qhat and din_a are all stage 2 needs
    assign qhat_c = RW'((PW'(din_a) * M_C) >> K);

`ifdef BARRETT_RANGE_CHK_EN
    localparam longint QQ = longint'(Q) * longint'(Q);
    logic ovf_p0, ovf_p1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            dout_r   <= '0;
            dout_tag <= '0;
`ifdef BARRETT_RANGE_CHK_EN
            dout_ovf <= 1'b0;
`endif
        end else if (en) begin
            vld_p0   <= din_valid;
            vld_p1   <= vld_p0;
            vld_p2   <= vld_p1;
            // stage 3: corrected residue registered at the output
            dout_r   <= r_corr;
            dout_tag <= tag_p1;
`ifdef BARRETT_RANGE_CHK_EN
            dout_ovf <= ovf_p1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // stage 1: quotient estimate
            qhat_p0 <= qhat_c;
            a_p0    <= din_a[RW-1:0];
            tag_p0  <= din_tag;
            // stage 2: partial remainder modulo 2**RW
            r0_p1   <= a_p0 - qhat_p0 * Q_RW;
            tag_p1  <= tag_p0;
`ifdef BARRETT_RANGE_CHK_EN
            ovf_p0  <= (longint'(din_a) >= QQ);
            ovf_p1  <= ovf_p0;
`endif
        end
    end

    barrett_corr #(
        .Q (Q),
        .W (W)
    ) u_corr (
        .r0 (r0_p1),
        .r  (r_corr)
    );

endmodule
